// File: rtl/seq_mon_pkg.sv
`default_nettype none
// seq_mon_pkg: shared types and helpers for the "x ##DELAY y" monitor.
// Rev 1.0
package seq_mon_pkg;

    localparam int MAX_CNT_W = 64;
    localparam int NCH_DEF   = 4;
    localparam int CH_W      = (NCH_DEF > 1) ? $clog2(NCH_DEF) : 1;

    // Wide carrier for counters of any width up to MAX_CNT_W; callers cast down.
    typedef logic [MAX_CNT_W-1:0] cnt_t;

    function automatic int ch_width(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

    function automatic cnt_t sat_inc(input cnt_t cnt, input cnt_t max);
        return (cnt >= max) ? max : cnt + cnt_t'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_mon_chan.sv
`default_nettype none
// seq_mon_chan: one channel of the monitor - attempt history, pulses, counters.
// Rev 1.0
module seq_mon_chan
    import seq_mon_pkg::*;
#(
    parameter int DELAY = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             x,
    input  logic             y,
    output logic             hit_pulse,
    output logic             fail_pulse,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             fail_now
);

    localparam cnt_t c_MAX = cnt_t'((65'd1 << CNT_W) - 65'd1);

    logic [DELAY-1:0] r_hist;
    logic             r_hit_pulse;
    logic             r_fail_pulse;
    logic [CNT_W-1:0] r_hit_cnt;
    logic [CNT_W-1:0] r_fail_cnt;
    logic             w_due;
    logic             w_hit;
    logic             w_fail;

    // The oldest history bit is the attempt launched DELAY edges ago.
    assign w_due    = r_hist[DELAY-1];
    assign w_hit    = w_due & y;
    assign w_fail   = w_due & ~y;
    assign fail_now = w_fail & ~clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hist       <= '0;
            r_hit_pulse  <= 1'b0;
            r_fail_pulse <= 1'b0;
            r_hit_cnt    <= '0;
            r_fail_cnt   <= '0;
        end else if (clr) begin
            r_hist       <= '0;
            r_hit_pulse  <= 1'b0;
            r_fail_pulse <= 1'b0;
            r_hit_cnt    <= '0;
            r_fail_cnt   <= '0;
        end else begin
            r_hist[0] <= en & x;
            for (int i = 1; i < DELAY; i++) begin
                r_hist[i] <= r_hist[i-1];
            end
            r_hit_pulse  <= w_hit;
            r_fail_pulse <= w_fail;
            if (w_hit) begin
                r_hit_cnt <= CNT_W'(sat_inc(cnt_t'(r_hit_cnt), c_MAX));
            end
            if (w_fail) begin
                r_fail_cnt <= CNT_W'(sat_inc(cnt_t'(r_fail_cnt), c_MAX));
            end
        end
    end

    assign hit_pulse  = r_hit_pulse;
    assign fail_pulse = r_fail_pulse;
    assign hit_cnt    = r_hit_cnt;
    assign fail_cnt   = r_fail_cnt;

endmodule
`default_nettype wire

// File: rtl/seq_delay_monitor.sv
`default_nettype none
// seq_delay_monitor: multi-channel "x ##DELAY y" match/fail monitor with first-fail capture.
// Rev 1.0
module seq_delay_monitor
    import seq_mon_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int DELAY = 1,
    parameter int CNT_W = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      clr,
    input  logic [NCH-1:0]            x,
    input  logic [NCH-1:0]            y,
    output logic [NCH-1:0]            hit_pulse,
    output logic [NCH-1:0]            fail_pulse,
    output logic [NCH*CNT_W-1:0]      hit_cnt,
    output logic [NCH*CNT_W-1:0]      fail_cnt,
    output logic                      first_fail_vld,
    output logic [ch_width(NCH)-1:0]  first_fail_ch
);

    localparam int CH_W_L = ch_width(NCH);

    logic [NCH-1:0]    w_fail_now;
    logic [CH_W_L-1:0] w_first_idx;
    logic              r_ff_vld;
    logic [CH_W_L-1:0] r_ff_ch;

    generate
        for (genvar c = 0; c < NCH; c++) begin : g_ch
            seq_mon_chan #(
                .DELAY (DELAY),
                .CNT_W (CNT_W)
            ) u_chan (
                .clk        (clk),
                .rst_n      (rst_n),
                .en         (en),
                .clr        (clr),
                .x          (x[c]),
                .y          (y[c]),
                .hit_pulse  (hit_pulse[c]),
                .fail_pulse (fail_pulse[c]),
                .hit_cnt    (hit_cnt[c*CNT_W +: CNT_W]),
                .fail_cnt   (fail_cnt[c*CNT_W +: CNT_W]),
                .fail_now   (w_fail_now[c])
            );
        end
    endgenerate

    // Scan from the top down so the lowest failing index wins.
    always_comb begin
        w_first_idx = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (w_fail_now[i]) begin
                w_first_idx = CH_W_L'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ff_vld <= 1'b0;
            r_ff_ch  <= '0;
        end else if (clr) begin
            r_ff_vld <= 1'b0;
            r_ff_ch  <= '0;
        end else if (!r_ff_vld && (|w_fail_now)) begin
            r_ff_vld <= 1'b1;
            r_ff_ch  <= w_first_idx;
        end
    end

    assign first_fail_vld = r_ff_vld;
    assign first_fail_ch  = r_ff_ch;

endmodule
`default_nettype wire
